value_fetch_arbiter: RTL and testbench



---
 rtl/value_fetch_arbiter_pkg.sv | 19 +
 rtl/value_fetch_arbiter_rr_arbiter.sv | 33 +++
 rtl/value_fetch_arbiter.sv | 164 ++++++++++++++++
 tb/tb_value_fetch_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/value_fetch_arbiter_pkg.sv
// Shared types for the value-fetch arbiter: lane-id width, FSM states and the
// read-tag record that travels alongside each memory read.
package value_fetch_arbiter_pkg;

  localparam int VFA_NUM_LANES = 4;
  localparam int LANE_W        = $clog2(VFA_NUM_LANES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
  } tag_t;

endpackage

// File: rtl/value_fetch_arbiter_rr_arbiter.sv
// Round-robin pick: searches from ptr+1 (wrapping) and returns the first
// requesting lane as a one-hot grant plus its index.
module rr_arbiter
  import value_fetch_arbiter_pkg::*;
#(
  parameter int NUM_LANES = VFA_NUM_LANES
) (
  input  logic [NUM_LANES-1:0] req,
  input  logic [LANE_W-1:0]    ptr,
  output logic [NUM_LANES-1:0] gnt,
  output logic [LANE_W-1:0]    idx,
  output logic                 any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    cand = 0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int off = 1; off <= NUM_LANES; off++) begin
      cand = (int'(ptr) + off) % NUM_LANES;
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = LANE_W'(cand);
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/value_fetch_arbiter.sv
// Shares one fixed-latency value-memory read port among NUM_LANES lanes and
// routes each returned word back to its lane. VALUE_FETCH_ARB_STRICT_PRIO_EN
// selects fixed lowest-index priority instead of round-robin.
module value_fetch_arbiter
  import value_fetch_arbiter_pkg::*;
#(
  parameter int NUM_LANES = VFA_NUM_LANES,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MEM_LAT   = 2,
  parameter int MAX_OUT   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_LANES-1:0]          lane_req,
  input  logic [NUM_LANES*ADDR_W-1:0]   lane_addr,
  output logic [NUM_LANES-1:0]          lane_gnt,
  output logic                          mem_rd,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic [NUM_LANES-1:0]          resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          busy
);

  localparam int CNT_W = $clog2(MAX_OUT + 1);

  state_t                state_q, state_d;
  tag_t                  tag_q [MEM_LAT+1];
  tag_t                  tag_d [MEM_LAT+1];
  logic [CNT_W-1:0]      out_cnt_q [NUM_LANES];
  logic [CNT_W-1:0]      out_cnt_d [NUM_LANES];
  logic                  mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [NUM_LANES-1:0]  resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]     resp_data_q, resp_data_d;

  logic [NUM_LANES-1:0]  elig, gnt_raw;
  logic [LANE_W-1:0]     gnt_idx;
  logic                  gnt_any, grant_en, grant, inflight;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      elig[i] = lane_req[i] && (out_cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  assign grant_en = (state_q == ST_RUN) && en;
  assign grant    = grant_en && gnt_any;
  assign lane_gnt = grant_en ? gnt_raw : '0;

`ifdef VALUE_FETCH_ARB_STRICT_PRIO_EN
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        gnt_raw    = '0;
        gnt_raw[i] = 1'b1;
        gnt_idx    = LANE_W'(i);
        gnt_any    = 1'b1;
      end
    end
  end
`else
  logic [LANE_W-1:0] ptr_q, ptr_d;

  rr_arbiter #(.NUM_LANES(NUM_LANES)) u_rr (
    .req (elig),
    .ptr (ptr_q),
    .gnt (gnt_raw),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= LANE_W'(NUM_LANES - 1);
    else      ptr_q <= ptr_d;
  end
`endif

  always_comb begin
    inflight = 1'b0;
    for (int k = 0; k <= MEM_LAT; k++) inflight = inflight | tag_q[k].valid;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en)             state_d = ST_RUN;
        else if (!inflight) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_d   = grant;
    mem_addr_d = mem_addr_q;
    if (grant) mem_addr_d = lane_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

    tag_d[0].valid = grant;
    tag_d[0].lane  = gnt_idx;
    for (int k = 1; k <= MEM_LAT; k++) tag_d[k] = tag_q[k-1];

    // The last tag stage lines up with the cycle mem_data is valid.
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    if (tag_q[MEM_LAT].valid) begin
      resp_valid_d[tag_q[MEM_LAT].lane] = 1'b1;
      resp_data_d                       = mem_data;
    end

    for (int i = 0; i < NUM_LANES; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      unique case ({grant && (gnt_idx == LANE_W'(i)), resp_valid_q[i]})
        2'b10:   out_cnt_d[i] = out_cnt_q[i] + 1'b1;
        2'b01:   out_cnt_d[i] = out_cnt_q[i] - 1'b1;
        default: out_cnt_d[i] = out_cnt_q[i];
      endcase
    end
  end

  // NOTE: non-blocking assignments here so every flop samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      mem_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      // NOTE: the tag array is reset because its valid bits are control state;
      // dropping them is what discards in-flight reads on reset.
      for (int k = 0; k <= MEM_LAT; k++) tag_q[k] <= '0;
      for (int i = 0; i < NUM_LANES; i++) out_cnt_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      mem_rd_q     <= mem_rd_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      for (int k = 0; k <= MEM_LAT; k++) tag_q[k] <= tag_d[k];
      for (int i = 0; i < NUM_LANES; i++) out_cnt_q[i] <= out_cnt_d[i];
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_value_fetch_arbiter.sv
// Self-checking bench for value_fetch_arbiter: directed scenarios plus random
// traffic, compared each cycle against a transaction-level reference model.
module tb_value_fetch_arbiter;

  localparam int N  = 4;
  localparam int A  = 16;
  localparam int D  = 32;
  localparam int L  = 2;
  localparam int MO = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [N-1:0]     lane_req;
  logic [N*A-1:0]   lane_addr;
  logic [N-1:0]     lane_gnt;
  logic             mem_rd;
  logic [A-1:0]     mem_addr;
  logic [D-1:0]     mem_data;
  logic [N-1:0]     resp_valid;
  logic [D-1:0]     resp_data;
  logic             busy;

  always #5 clk = ~clk;

  value_fetch_arbiter #(
    .NUM_LANES(N), .ADDR_W(A), .DATA_W(D), .MEM_LAT(L), .MAX_OUT(MO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .lane_req   (lane_req),
    .lane_addr  (lane_addr),
    .lane_gnt   (lane_gnt),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy)
  );

  function automatic logic [D-1:0] mem_fn(input logic [A-1:0] a);
    return {a ^ 16'h3C5A, a};
  endfunction

  // Fixed-latency memory: data for a read strobed in cycle c is driven in cycle c+L.
  logic         hist_v [L];
  logic [A-1:0] hist_a [L];
  logic [D-1:0] junk;
  always @(posedge clk) begin
    hist_v[0] <= mem_rd;
    hist_a[0] <= mem_addr;
    for (int k = 1; k < L; k++) begin
      hist_v[k] <= hist_v[k-1];
      hist_a[k] <= hist_a[k-1];
    end
    junk <= $urandom;
  end
  assign mem_data = hist_v[L-1] ? mem_fn(hist_a[L-1]) : junk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int           due;
    int           lane;
    logic [A-1:0] addr;
  } rd_t;

  rd_t          q[$];
  int           cyc;
  int           exp_cnt [N];
  int           last_g;
  bit           en_h1, en_h2, busy_prev, pend_prev;
  logic         exp_mem_rd;
  logic [A-1:0] exp_mem_addr;
  logic [D-1:0] exp_resp_data;

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) exp_cnt[i] = 0;
    last_g        = N - 1;
    en_h1         = 1'b0;
    en_h2         = 1'b0;
    busy_prev     = 1'b0;
    pend_prev     = 1'b0;
    exp_mem_rd    = 1'b0;
    exp_mem_addr  = '0;
    exp_resp_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   64'(lane_gnt),   64'd0);
    check({tag, "_rd"},    64'(mem_rd),     64'd0);
    check({tag, "_addr"},  64'(mem_addr),   64'd0);
    check({tag, "_rv"},    64'(resp_valid), 64'd0);
    check({tag, "_rdata"}, 64'(resp_data),  64'd0);
    check({tag, "_busy"},  64'(busy),       64'd0);
  endtask

  // One clock cycle: drive inputs just after the rising edge, compare at the falling edge.
  task automatic step(input bit en_i, input logic [N-1:0] req_i, input logic [N*A-1:0] addr_i);
    int           g;
    int           c;
    bit           rsp;
    bit           exp_busy;
    logic [N-1:0] exp_gnt;
    logic [N-1:0] exp_rv;
    logic [D-1:0] exp_rd;
    rd_t          r;
    en        = en_i;
    lane_req  = req_i;
    lane_addr = addr_i;

    g = -1;
    if (en_h1 && en_i) begin
`ifdef VALUE_FETCH_ARB_STRICT_PRIO_EN
      for (int i = 0; i < N; i++)
        if (g < 0 && req_i[i] && exp_cnt[i] < MO) g = i;
`else
      for (int k = 1; k <= N; k++) begin
        c = (last_g + k) % N;
        if (g < 0 && req_i[c] && exp_cnt[c] < MO) g = c;
      end
`endif
    end
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;

    rsp    = (q.size() > 0) && (q[0].due == cyc);
    exp_rv = '0;
    exp_rd = exp_resp_data;
    if (rsp) begin
      exp_rv[q[0].lane] = 1'b1;
      exp_rd            = mem_fn(q[0].addr);
    end
    exp_busy = en_h1 || en_h2 || (busy_prev && pend_prev);

    @(negedge clk);
    check("lane_gnt",   64'(lane_gnt),   64'(exp_gnt));
    check("mem_rd",     64'(mem_rd),     64'(exp_mem_rd));
    check("mem_addr",   64'(mem_addr),   64'(exp_mem_addr));
    check("resp_valid", 64'(resp_valid), 64'(exp_rv));
    check("resp_data",  64'(resp_data),  64'(exp_rd));
    check("busy",       64'(busy),       64'(exp_busy));

    if (rsp) begin
      r = q.pop_front();
      exp_cnt[r.lane]--;
      exp_resp_data = exp_rd;
    end
    pend_prev  = (q.size() > 0);
    exp_mem_rd = (g >= 0);
    if (g >= 0) begin
      q.push_back('{due: cyc + 2 + L, lane: g, addr: addr_i[g*A +: A]});
      exp_cnt[g]++;
      last_g       = g;
      exp_mem_addr = addr_i[g*A +: A];
    end
    busy_prev = exp_busy;
    en_h2     = en_h1;
    en_h1     = en_i;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*A-1:0] rand_addr();
    logic [N*A-1:0] v;
    for (int i = 0; i < N; i++) v[i*A +: A] = A'($urandom);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N*A-1:0] ad;
    cyc       = 0;
    rst       = 1'b0;
    en        = 1'b0;
    lane_req  = '0;
    lane_addr = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single request from lane 0 at address 0x10.
    ad = rand_addr();
    ad[0 +: A] = 16'h0010;
    step(1'b1, 4'b0000, ad);
    step(1'b1, 4'b0001, ad);
    for (int i = 0; i < 6; i++) step(1'b1, 4'b0000, ad);

    // All lanes requesting continuously: rotation and per-lane limit.
    for (int i = 0; i < 14; i++) step(1'b1, 4'b1111, rand_addr());
    for (int i = 0; i < 6; i++)  step(1'b1, 4'b0000, rand_addr());

    // Lane 2 alone: stalls at its outstanding limit, resumes on responses.
    for (int i = 0; i < 14; i++) step(1'b1, 4'b0100, rand_addr());
    for (int i = 0; i < 6; i++)  step(1'b1, 4'b0000, rand_addr());

    // Drop en with reads in flight; requests stay high.
    for (int i = 0; i < 3; i++)  step(1'b1, 4'b1011, rand_addr());
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1011, rand_addr());

    // Re-enable, then reset mid-flight.
    for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, rand_addr());
    rst      = 1'b0;
    en       = 1'b0;
    lane_req = '0;
    #2;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++)  step(1'b0, 4'b0000, rand_addr());
    step(1'b1, 4'b0000, rand_addr());
    for (int i = 0; i < 10; i++) step(1'b1, 4'b1111, rand_addr());

    // Lanes 1 and 3 held.
    for (int i = 0; i < 12; i++) step(1'b1, 4'b1010, rand_addr());
    for (int i = 0; i < 6; i++)  step(1'b1, 4'b0000, rand_addr());

    // Random traffic with occasional en drops.
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) != 0), N'($urandom), rand_addr());
    for (int i = 0; i < 8; i++) step(1'b0, 4'b0000, rand_addr());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
